// File: rtl/simple_fifo_pkg.sv
// simple_fifo_pkg: output FSM state encodings and depth/count-width helpers shared by the FIFO files
package simple_fifo_pkg;
  typedef enum logic {S_EMPTY, S_VALID} state_t;
  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction
  function automatic int unsigned count_width(input int unsigned addr_size);
    return addr_size + 1;
  endfunction
endpackage

// File: rtl/simple_memory.sv
// simple_memory: 2^ADDR_SIZE x DATA_SIZE storage, one write port and one registered read port
module simple_memory
  import simple_fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_SIZE-1:0] wr_addr_i,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  input  logic [ADDR_SIZE-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0] rd_data_o
);
  localparam int DEPTH = fifo_depth(ADDR_SIZE);
  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] rd_data_q;
  // Read returns the old contents when reading and writing the same address on one edge
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end
  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/simple_fifo.sv
// simple_fifo: valid/ready FIFO over simple_memory with a two-state output FSM.
// Define SIMPLE_FIFO_HWM_EN to add the max_count high-water-mark output.
module simple_fifo
  import simple_fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE:0]   count
`ifdef SIMPLE_FIFO_HWM_EN
  ,
  output logic [ADDR_SIZE:0]   max_count
`endif
);
  localparam int CW = count_width(ADDR_SIZE);
  localparam logic [CW-1:0] DEPTH = CW'(fifo_depth(ADDR_SIZE));
  state_t state_q, state_d;
  logic [CW-1:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic push, pop, unused_ptr_msb;
  assign in_ready = count_q < DEPTH;
  assign out_valid = state_q == S_VALID;
  assign push = in_valid && in_ready && !rst;
  assign pop = out_valid && out_ready && !rst;
  // Reading one slot ahead on a pop keeps the registered read data on the new head
  assign rd_addr = rd_ptr_q[ADDR_SIZE-1:0] + ADDR_SIZE'(pop);
  assign count = count_q;
  assign unused_ptr_msb = wr_ptr_q[CW-1] ^ rd_ptr_q[CW-1];
  always_comb begin
    count_d = push && !pop ? count_q + CW'(1) : pop && !push ? count_q - CW'(1) : count_q;
    state_d = state_q == S_EMPTY ? (count_q != '0 ? S_VALID : S_EMPTY)
                                 : (pop && count_q <= CW'(1) ? S_EMPTY : S_VALID);
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end
`ifdef SIMPLE_FIFO_HWM_EN
  logic [CW-1:0] max_q;
  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else if (count_d > max_q) max_q <= count_d;
  end
  assign max_count = max_q;
`endif
  simple_memory #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk      (clk),
    .wr_en_i  (push),
    .wr_addr_i(wr_ptr_q[ADDR_SIZE-1:0]),
    .wr_data_i(in_data),
    .rd_addr_i(rd_addr),
    .rd_data_o(out_data)
  );
endmodule

// File: tb/tb_simple_fifo.sv
// tb_simple_fifo: scoreboard bench for simple_fifo at DATA_SIZE=8, ADDR_SIZE=2
module tb_simple_fifo;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] count;
`ifdef SIMPLE_FIFO_HWM_EN
  logic [2:0] max_count;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  simple_fifo #(.DATA_SIZE(8), .ADDR_SIZE(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count)
`ifdef SIMPLE_FIFO_HWM_EN
    , .max_count(max_count)
`endif
  );

  // Drive one cycle of inputs, return at mid-cycle, and log accepted pushes as expectations
  task automatic drive(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    @(posedge clk); #1;
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    if (in_valid && in_ready && !rst) q.push_back(d);
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset: count=%0h out_valid=%b in_ready=%b expected 0/0/1", count, out_valid, in_ready);
    end
`ifdef SIMPLE_FIFO_HWM_EN
    n_cmp++;
    if (max_count !== 3'd0) begin n_bad++; $display("FAIL reset_max: got %0h expected 0", max_count); end
`endif
  endtask

  task automatic test_single;
    logic [7:0] exp;
    drive(0, 1, 8'hA5, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (count !== 3'd1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_c1: count=%0h out_valid=%b expected 1/0", count, out_valid);
    end
    drive(0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_c2_valid: got %b expected 1", out_valid); end
    if (out_valid && out_ready) begin
      n_cmp++;
      exp = q.size() != 0 ? q.pop_front() : 8'hxx;
      if (out_data !== exp) begin n_bad++; $display("FAIL single_data: got %0h expected %0h", out_data, exp); end
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++; $display("FAIL single_empty: out_valid=%b count=%0h expected 0/0", out_valid, count);
    end
  endtask

  task automatic test_full;
    logic [7:0] exp;
    logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (pat[i]) drive(0, 1, pat[i], 0);
    drive(0, 1, 8'h55, 0);
    n_cmp++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL full: count=%0h in_ready=%b expected 4/0", count, in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_bad++; $display("FAIL full_head: valid=%b data=%0h expected 1/11", out_valid, out_data);
    end
    drive(0, 1, 8'h55, 1);
    n_cmp++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      n_bad++; $display("FAIL full_pop_ready: in_ready=%b count=%0h expected 0/4", in_ready, count);
    end
    if (out_valid && out_ready) begin
      n_cmp++;
      exp = q.size() != 0 ? q.pop_front() : 8'hxx;
      if (out_data !== exp) begin n_bad++; $display("FAIL full_pop_data: got %0h expected %0h", out_data, exp); end
    end
    drive(0, 1, 8'h66, 0);
    n_cmp++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL after_pop: count=%0h in_ready=%b expected 3/1", count, in_ready);
    end
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, 0, 1);
      if (j == 0) begin
        n_cmp++;
        if (count !== 3'd4) begin n_bad++; $display("FAIL refill: count=%0h expected 4", count); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        exp = q.size() != 0 ? q.pop_front() : 8'hxx;
        if (out_data !== exp) begin n_bad++; $display("FAIL drain_data: got %0h expected %0h", out_data, exp); end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd0 || q.size() != 0) begin
      n_bad++; $display("FAIL drain_end: valid=%b count=%0h left=%0d expected 0/0/0", out_valid, count, q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    for (int i = 0; i < 24; i++) begin
      drive(0, i < 16, 8'(i), 1);
      if (i >= 2 && i < 18) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
      end
      if (i >= 2 && i < 16) begin
        n_cmp++;
        if (count !== 3'd2) begin n_bad++; $display("FAIL stream_count[%0d]: got %0h expected 2", i, count); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        exp = q.size() != 0 ? q.pop_front() : 8'hxx;
        if (out_data !== exp) begin n_bad++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, out_data, exp); end
      end
    end
    n_cmp++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_end: left=%0d valid=%b expected 0/0", q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp;
    drive(0, 1, 8'hAA, 0);
    drive(0, 1, 8'hBB, 0);
    drive(0, 1, 8'hCC, 0);
    drive(1, 1, 8'h77, 1);
    n_cmp++;
    if (count !== 3'd3) begin n_bad++; $display("FAIL pre_reset_count: got %0h expected 3", count); end
    q.delete();
    drive(0, 1, 8'h3C, 0);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset: count=%0h valid=%b in_ready=%b expected 0/0/1", count, out_valid, in_ready);
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd1) begin
      n_bad++; $display("FAIL mid_reset_c1: valid=%b count=%0h expected 0/1", out_valid, count);
    end
    drive(0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_reset_c2_valid: got %b expected 1", out_valid); end
    if (out_valid && out_ready) begin
      n_cmp++;
      exp = q.size() != 0 ? q.pop_front() : 8'hxx;
      if (out_data !== exp) begin n_bad++; $display("FAIL mid_reset_data: got %0h expected %0h", out_data, exp); end
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_bad++; $display("FAIL mid_reset_end: valid=%b count=%0h expected 0/0", out_valid, count);
    end
  endtask

`ifdef SIMPLE_FIFO_HWM_EN
  task automatic test_hwm;
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) drive(0, 1, 8'hE0 + 8'(i), 0);
    for (int j = 0; j < 8; j++) begin
      drive(0, 0, 0, 1);
      if (out_valid && out_ready) begin
        n_cmp++;
        exp = q.size() != 0 ? q.pop_front() : 8'hxx;
        if (out_data !== exp) begin n_bad++; $display("FAIL hwm_data: got %0h expected %0h", out_data, exp); end
      end
    end
    n_cmp++;
    if (max_count !== 3'd3 || count !== 3'd0) begin
      n_bad++; $display("FAIL hwm: max_count=%0h count=%0h expected 3/0", max_count, count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef SIMPLE_FIFO_HWM_EN
    test_hwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
